instruction_memory: RTL and testbench
=====================================

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of DATA_WIDTH-wide instruction words stored.
REQ-002 The block SHALL have parameter READ_LATENCY, default 1, legal range 1..4, meaning the number of cycles from request acceptance to ack.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port imem_req_i, input, 1 bit: fetch request from instruction_fetch.
REQ-006 The block SHALL have port imem_addr_i, input, ADDR_WIDTH bits: byte address of the requested instruction (PC).
REQ-007 The block SHALL have port imem_ack_o, output, 1 bit: one-cycle response-valid pulse.
REQ-008 The block SHALL have port imem_rdata_o, output, DATA_WIDTH bits: instruction word, valid while imem_ack_o=1.
REQ-009 The block SHALL have port imem_err_o, output, 1 bit: access fault, valid while imem_ack_o=1.
REQ-010 The block SHALL have port prog_we_i, input, 1 bit: program-load write enable.
REQ-011 The block SHALL have port prog_addr_i, input, ADDR_WIDTH bits: program-load byte address.
REQ-012 The block SHALL have port prog_wdata_i, input, DATA_WIDTH bits: program-load data.

Function
REQ-013 The block SHALL decode the word index as address bits [ADDR_WIDTH-1:1], so that consecutive PC values (step 2) map to consecutive words.
REQ-014 The block SHALL implement a controller with states IDLE, WAIT and RESP.
- IDLE with imem_req_i=1: accepts the request (captures index and fault status), then goes to WAIT, or directly to RESP when READ_LATENCY=1.
- WAIT: decrements a latency counter; goes to RESP when the counter reaches 1.
- RESP: imem_ack_o=1.
REQ-015 If imem_req_i=1 in RESP, the block SHALL accept a new request in that same cycle; otherwise it returns to IDLE.
REQ-016 With READ_LATENCY=1 and imem_req_i held high, the block SHALL assert imem_ack_o every cycle.
REQ-017 With READ_LATENCY=L, the block SHALL assert imem_ack_o exactly L cycles after the acceptance edge, and SHALL accept at most one request per L cycles.
REQ-018 The block SHALL ignore imem_req_i while in WAIT, with no queuing; the requester holds req and address until ack.
REQ-019 The block SHALL read the memory at the acceptance edge and hold the data in a response register.
- Later prog writes do not alter an in-flight response.
REQ-020 When imem_ack_o=0, the block SHALL drive imem_rdata_o and imem_err_o to 0.
REQ-021 When prog_we_i=1, the block SHALL write prog_wdata_i to word prog_addr_i[ADDR_WIDTH-1:1] at the clock edge, in any state.
REQ-022 On a write and an accept to the same index in the same cycle, the block SHALL return the old data (read-before-write).
REQ-023 The block SHALL reduce the word index modulo DEPTH, except as modified by IMEM_ERR_EN.

Reset
REQ-024 When rst_i=1 at a clock edge, the block SHALL go to IDLE, clear the latency counter and drive imem_ack_o=0, imem_rdata_o=0 and imem_err_o=0 from the next cycle.
REQ-025 Reset asserted mid-operation (WAIT or RESP) SHALL drop the pending response with no ack.
REQ-026 Reset SHALL NOT clear the memory contents.
REQ-027 The block SHALL ignore prog writes in a cycle where rst_i=1.

Configuration
REQ-028 When macro IMEM_ERR_EN is defined, the block SHALL flag a request whose address has bit0=1 or whose word index is >= DEPTH.
- The fault is recorded at acceptance.
- The ack is delivered with normal latency, imem_err_o=1 and imem_rdata_o=0.
- Faulting prog writes are discarded.
REQ-029 When IMEM_ERR_EN is undefined, the block SHALL tie imem_err_o to 0, ignore address bit0 and wrap the index modulo DEPTH for both reads and writes.

Structure
REQ-030 DATA_WIDTH, ADDR_WIDTH and the state enum type (IDLE/WAIT/RESP) SHALL reside in sp_pkg.
REQ-031 The storage array SHALL be a separate sub-module, imem_array: a 1-read/1-write synchronous RAM with read-before-write.
REQ-032 Handshake control SHALL reside in instruction_memory.
REQ-033 Under SIMULATION, the block SHALL report an error if READ_LATENCY is outside 1..4 or DEPTH is not a power of two.

Verification
REQ-034 Back-to-back reads: preload words 0..3 with 0x11,0x22,0x33,0x44; READ_LATENCY=1; req held high with addr 0,2,4,6 -> ack high for 4 consecutive cycles, rdata 0x11,0x22,0x33,0x44.
REQ-035 Latency 3: READ_LATENCY=3; request addr 4 with req held high -> ack after 3 cycles and every 3rd cycle after; rdata 0x33; no ack in the intervening cycles.
REQ-036 Write collision: in the same cycle, accept addr 2 and prog write 0xAA to addr 2 -> ack rdata 0x22; a following read of addr 2 returns 0xAA.
REQ-037 Reset mid-operation: READ_LATENCY=3; assert rst_i one cycle after accept -> no ack; outputs 0; a read of addr 0 after reset returns 0x11 (contents preserved).
REQ-038 Fault check, IMEM_ERR_EN defined: DEPTH=256; request addr 3 and addr 512 -> each acks with err=1, rdata 0.
REQ-039 Wrap check, IMEM_ERR_EN undefined: DEPTH=256; request addr 512 -> rdata 0x11, err=0.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared widths, controller state type and address-fault helper for the
// instruction-memory slice.
package sp_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned ADDR_WIDTH    = 32;
  localparam int unsigned LAT_CNT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } imem_state_e;

  // Misaligned (odd) byte address or word index beyond the populated depth.
  function automatic logic imem_addr_fault(input logic [ADDR_WIDTH-1:0] addr,
                                           input int unsigned           depth);
    return addr[0] || ((addr >> 1) >= ADDR_WIDTH'(depth));
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: 1-read/1-write synchronous RAM, read-before-write on a
// same-index collision. Contents are never reset.
module imem_array #(
  parameter  int unsigned DEPTH = 256,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/instruction_memory.sv
// Instruction memory with IDLE/WAIT/RESP fetch handshake and program-load port.
// Optional access-fault reporting is enabled by defining IMEM_ERR_EN.
module instruction_memory
  import sp_pkg::*;
#(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  imem_req_i,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  output logic                  imem_ack_o,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  output logic                  imem_err_o,
  input  logic                  prog_we_i,
  input  logic [ADDR_WIDTH-1:0] prog_addr_i,
  input  logic [DATA_WIDTH-1:0] prog_wdata_i
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef SIMULATION
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("instruction_memory: READ_LATENCY must be within 1..4");
  end
  if (DEPTH == 0 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instruction_memory: DEPTH must be a power of two");
  end
`endif

  imem_state_e              state;
  logic [LAT_CNT_WIDTH-1:0] lat_cnt;
  logic                     ack_q;
  logic                     err_q;
  logic                     req_fault;
  logic                     wr_fault;
  logic                     accept;
  logic                     ram_we;
  logic [DATA_WIDTH-1:0]    ram_rdata;
  logic                     unused_addr_bits;

`ifdef IMEM_ERR_EN
  assign req_fault = imem_addr_fault(imem_addr_i, DEPTH);
  assign wr_fault  = imem_addr_fault(prog_addr_i, DEPTH);
`else
  assign req_fault = 1'b0;
  assign wr_fault  = 1'b0;
`endif

  // Index bits above the depth wrap away; bit0 only matters for fault checks.
  assign unused_addr_bits = ^{imem_addr_i[0], imem_addr_i[ADDR_WIDTH-1:IDX_W+1],
                              prog_addr_i[0], prog_addr_i[ADDR_WIDTH-1:IDX_W+1]};

  assign accept = imem_req_i && !rst_i && (state != WAIT);
  assign ram_we = prog_we_i && !rst_i && !wr_fault;

  // The RAM read register only loads on accept, so it doubles as the response register.
  imem_array #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (prog_addr_i[IDX_W:1]),
    .wdata_i (prog_wdata_i),
    .re_i    (accept),
    .raddr_i (imem_addr_i[IDX_W:1]),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      lat_cnt <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        IDLE, RESP: begin
          if (imem_req_i) begin
            err_q <= req_fault;
            if (READ_LATENCY == 1) begin
              state <= RESP;
              ack_q <= 1'b1;
            end else begin
              state   <= WAIT;
              lat_cnt <= LAT_CNT_WIDTH'(READ_LATENCY - 1);
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_CNT_WIDTH'(1)) begin
            state <= RESP;
            ack_q <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_ack_o   = ack_q;
  assign imem_err_o   = ack_q && err_q;
  assign imem_rdata_o = (ack_q && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench: one latency-1 and one latency-3 instance against a
// time-based reference model, plus directed literal scenarios.
module tb_instruction_memory;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;

  logic        req1, ack1, err1;
  logic [31:0] addr1, rdata1;
  logic        req3, ack3, err3;
  logic [31:0] addr3, rdata3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_memory #(.DEPTH(DEPTH), .READ_LATENCY(1)) dut_l1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_req_i   (req1),
    .imem_addr_i  (addr1),
    .imem_ack_o   (ack1),
    .imem_rdata_o (rdata1),
    .imem_err_o   (err1),
    .prog_we_i    (prog_we),
    .prog_addr_i  (prog_addr),
    .prog_wdata_i (prog_wdata)
  );

  instruction_memory #(.DEPTH(DEPTH), .READ_LATENCY(3)) dut_l3 (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_req_i   (req3),
    .imem_addr_i  (addr3),
    .imem_ack_o   (ack3),
    .imem_rdata_o (rdata3),
    .imem_err_o   (err3),
    .prog_we_i    (prog_we),
    .prog_addr_i  (prog_addr),
    .prog_wdata_i (prog_wdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image plus one outstanding response per port,
  // tracked by the edge number on which its ack becomes visible.
  typedef struct {
    bit          out;
    int          ack_at;
    logic [31:0] data;
    bit          err;
  } pend_t;

  logic [31:0] mem_m [DEPTH];
  pend_t       p1, p3;
  int          n        = 0;
  bit          model_ok = 1'b0;

  function automatic bit m_fault(input logic [31:0] a);
`ifdef IMEM_ERR_EN
    return a[0] || ((a >> 1) >= DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 1) % DEPTH);
  endfunction

  task automatic model_port(inout pend_t p, input int lat, input bit req, input logic [31:0] a);
    if (rst) begin
      p.out = 1'b0;
    end else begin
      if (p.out && p.ack_at < n) p.out = 1'b0;
      if (req && !p.out) begin
        p.out    = 1'b1;
        p.ack_at = n + lat - 1;
        p.err    = m_fault(a);
        p.data   = p.err ? 32'h0 : mem_m[m_idx(a)];
      end
    end
  endtask

  always @(posedge clk) begin
    n++;
    model_port(p1, 1, req1, addr1);
    model_port(p3, 3, req3, addr3);
    if (!rst && prog_we && !m_fault(prog_addr)) mem_m[m_idx(prog_addr)] = prog_wdata;
    model_ok = 1'b1;
  end

  function automatic bit e_ack(input pend_t p);
    return p.out && (p.ack_at == n);
  endfunction

  always @(negedge clk) begin
    if (model_ok) begin
      check("ack_l1",   ack1,   e_ack(p1));
      check("rdata_l1", rdata1, e_ack(p1) ? p1.data : 32'h0);
      check("err_l1",   err1,   e_ack(p1) && p1.err);
      check("ack_l3",   ack3,   e_ack(p3));
      check("rdata_l3", rdata3, e_ack(p3) ? p3.data : 32'h0);
      check("err_l3",   err3,   e_ack(p3) && p3.err);
    end
  end

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) != 0) return 32'($urandom_range(0, DEPTH - 1)) * 2;
    return 32'($urandom_range(0, 4 * DEPTH));
  endfunction

  initial begin
    logic [31:0] lit [4];
    bit          got;
    lit = '{32'h11, 32'h22, 32'h33, 32'h44};
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    req1 = 1'b0; addr1 = '0; req3 = 1'b0; addr3 = '0;
    repeat (3) @(negedge clk);
    check("reset_ack_l1", ack1, 0);
    check("reset_rdata_l3", rdata3, 0);
    rst = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++) begin
      prog_we    = 1'b1;
      prog_addr  = 32'(i) * 2;
      prog_wdata = (i < 4) ? lit[i] : $urandom;
      @(negedge clk);
    end
    prog_we = 1'b0;

    // Back-to-back reads at latency 1.
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr1 = 32'(i) * 2;
      @(negedge clk);
      check("b2b_ack", ack1, 1);
      check("b2b_rdata", rdata1, lit[i]);
    end
    req1 = 1'b0;
    @(negedge clk);

    // Latency 3 with request held: ack every third cycle.
    req3 = 1'b1; addr3 = 32'd4;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("lat3_ack", ack3, (c % 3) == 0);
      if ((c % 3) == 0) check("lat3_rdata", rdata3, 32'h33);
    end
    req3 = 1'b0;
    @(negedge clk);

    // Read/write collision returns the old word.
    req1 = 1'b1; addr1 = 32'd2;
    prog_we = 1'b1; prog_addr = 32'd2; prog_wdata = 32'hAA;
    @(negedge clk);
    check("coll_ack", ack1, 1);
    check("coll_old", rdata1, 32'h22);
    prog_we = 1'b0;
    @(negedge clk);
    check("coll_new", rdata1, 32'hAA);
    req1 = 1'b0;
    @(negedge clk);

    // Reset one cycle after accept drops the response; writes under reset ignored.
    req3 = 1'b1; addr3 = 32'd0;
    @(negedge clk);
    rst = 1'b1; req3 = 1'b0;
    prog_we = 1'b1; prog_addr = 32'd0; prog_wdata = 32'h99;
    @(negedge clk);
    rst = 1'b0; prog_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rst_no_ack", ack3, 0);
      check("rst_rdata0", rdata3, 0);
      @(negedge clk);
    end
    req3 = 1'b1;
    got  = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (ack3) begin
        got = 1'b1;
        check("rst_preserved", rdata3, 32'h11);
      end
    end
    check("rst_read_ack_seen", got, 1);
    req3 = 1'b0;
    @(negedge clk);

    // Out-of-range and odd addresses.
    req1 = 1'b1; addr1 = 32'd512;
    @(negedge clk);
    check("far_ack", ack1, 1);
`ifdef IMEM_ERR_EN
    check("far_err", err1, 1);
    check("far_rdata", rdata1, 0);
`else
    check("far_err", err1, 0);
    check("far_rdata", rdata1, 32'h11);
`endif
    addr1 = 32'd3;
    @(negedge clk);
`ifdef IMEM_ERR_EN
    check("odd_err", err1, 1);
    check("odd_rdata", rdata1, 0);
`else
    check("odd_err", err1, 0);
    check("odd_rdata", rdata1, 32'hAA);
`endif
    req1 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      req1 = ($urandom_range(0, 3) != 0);
      req3 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) addr1 = rand_addr();
      if ($urandom_range(0, 2) == 0) addr3 = rand_addr();
      prog_we    = ($urandom_range(0, 5) == 0);
      prog_addr  = rand_addr();
      prog_wdata = $urandom;
      @(negedge clk);
    end
    rst = 1'b0; req1 = 1'b0; req3 = 1'b0; prog_we = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
